// File: rtl/spgd_dither_sequencer.sv
//------------------------------------------------------------------------------
// spgd_dither_sequencer
//   Applies +delta then -delta through DAC_SEL, settles, accumulates metric
//   samples per polarity and reports J+, J- and dJ for the SPGD update.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module spgd_dither_sequencer #(
    parameter int ADC_WIDTH     = 14,
    parameter int SETTLE_CYCLES = 16,
    parameter int AVG_LOG2      = 4,
    parameter int CNT_WIDTH     = 16
) (
    input  logic                            CLK,
    input  logic                            RST,
    input  logic                            ENABLE,
    input  logic                            START,
    input  logic [ADC_WIDTH-1:0]            ADC_DATA,
    input  logic                            ADC_VALID,
    output logic [1:0]                      DAC_SEL,
    output logic                            BUSY,
    output logic [ADC_WIDTH+AVG_LOG2-1:0]   J_PLUS,
    output logic [ADC_WIDTH+AVG_LOG2-1:0]   J_MINUS,
    output logic [ADC_WIDTH+AVG_LOG2:0]     DJ,
    output logic                            DJ_VALID
);

    localparam int SUM_W = ADC_WIDTH + AVG_LOG2;
    localparam logic [CNT_WIDTH-1:0] SETTLE_LAST = CNT_WIDTH'(SETTLE_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] SAMPLE_LAST = CNT_WIDTH'((1 << AVG_LOG2) - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SET_P = 3'd1;
    localparam logic [2:0] S_ACC_P = 3'd2;
    localparam logic [2:0] S_SET_M = 3'd3;
    localparam logic [2:0] S_ACC_M = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    logic [2:0]           state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [SUM_W-1:0]     acc_q, acc_d;
    logic [SUM_W-1:0]     jp_hold_q, jp_hold_d;
    logic [SUM_W-1:0]     jplus_q, jplus_d;
    logic [SUM_W-1:0]     jminus_q, jminus_d;
    logic [SUM_W:0]       dj_q, dj_d;
    logic [1:0]           dac_sel_q, dac_sel_d;
    logic                 busy_q, busy_d;
    logic                 dj_valid_q, dj_valid_d;
    logic [SUM_W-1:0]     sample_ext;
    logic [SUM_W-1:0]     acc_next;

    assign sample_ext = {{AVG_LOG2{ADC_DATA[ADC_WIDTH-1]}}, ADC_DATA};
    assign acc_next   = acc_q + sample_ext;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (!ENABLE) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:  if (START) state_d = S_SET_P;
                S_SET_P: if (cnt_q == SETTLE_LAST) state_d = S_ACC_P;
                S_ACC_P: if (ADC_VALID && cnt_q == SAMPLE_LAST) state_d = S_SET_M;
                S_SET_M: if (cnt_q == SETTLE_LAST) state_d = S_ACC_M;
                S_ACC_M: if (ADC_VALID && cnt_q == SAMPLE_LAST) state_d = S_DONE;
                S_DONE:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Outputs are registered, so they are decoded from the upcoming state.
    always_comb begin
        dac_sel_d  = 2'b00;
        case (state_d)
            S_IDLE:           dac_sel_d = ENABLE ? 2'b11 : 2'b00;
            S_SET_P, S_ACC_P: dac_sel_d = 2'b01;
            S_SET_M, S_ACC_M: dac_sel_d = 2'b10;
            S_DONE:           dac_sel_d = 2'b11;
            default:          dac_sel_d = 2'b00;
        endcase
        busy_d     = (state_d != S_IDLE);
        dj_valid_d = (state_d == S_DONE);
    end

    always_comb begin
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        jp_hold_d = jp_hold_q;
        jplus_d   = jplus_q;
        jminus_d  = jminus_q;
        dj_d      = dj_q;
        case (state_q)
            S_SET_P, S_SET_M: begin
                cnt_d = cnt_q + 1'b1;
                if (state_d != state_q) begin
                    cnt_d = '0;
                    acc_d = '0;
                end
            end
            S_ACC_P, S_ACC_M: begin
                if (ADC_VALID) begin
                    acc_d = acc_next;
                    cnt_d = cnt_q + 1'b1;
                end
                if (state_d == S_SET_M) begin
                    cnt_d     = '0;
                    jp_hold_d = acc_next;
                end
                if (state_d == S_DONE) begin
                    jplus_d  = jp_hold_q;
                    jminus_d = acc_next;
                    dj_d     = {jp_hold_q[SUM_W-1], jp_hold_q} - {acc_next[SUM_W-1], acc_next};
                end
            end
            default: begin
                cnt_d = '0;
                acc_d = '0;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cnt_q      <= '0;
            acc_q      <= '0;
            jp_hold_q  <= '0;
            jplus_q    <= '0;
            jminus_q   <= '0;
            dj_q       <= '0;
            dac_sel_q  <= 2'b00;
            busy_q     <= 1'b0;
            dj_valid_q <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            jp_hold_q  <= jp_hold_d;
            jplus_q    <= jplus_d;
            jminus_q   <= jminus_d;
            dj_q       <= dj_d;
            dac_sel_q  <= dac_sel_d;
            busy_q     <= busy_d;
            dj_valid_q <= dj_valid_d;
        end
    end

    assign DAC_SEL  = dac_sel_q;
    assign BUSY     = busy_q;
    assign J_PLUS   = jplus_q;
    assign J_MINUS  = jminus_q;
    assign DJ       = dj_q;
    assign DJ_VALID = dj_valid_q;

endmodule

`default_nettype wire

// File: tb/tb_spgd_dither_sequencer.sv
//------------------------------------------------------------------------------
// tb_spgd_dither_sequencer
//   Randomized bench; expected timing and sums are derived from per-edge
//   stimulus tables by scanning for accepted samples.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_spgd_dither_sequencer;

    localparam int ADC_W  = 14;
    localparam int SETTLE = 16;
    localparam int AVGL   = 4;
    localparam int CNTW   = 16;
    localparam int N      = 1 << AVGL;
    localparam int SW     = ADC_W + AVGL;
    localparam int MAXE   = 600;
    localparam int RANDV  = 1 << 30;

    logic              CLK = 1'b0;
    logic              RST, ENABLE, START, ADC_VALID;
    logic [ADC_W-1:0]  ADC_DATA;
    logic [1:0]        DAC_SEL;
    logic              BUSY, DJ_VALID;
    logic [SW-1:0]     J_PLUS, J_MINUS;
    logic [SW:0]       DJ;

    spgd_dither_sequencer #(
        .ADC_WIDTH(ADC_W), .SETTLE_CYCLES(SETTLE), .AVG_LOG2(AVGL), .CNT_WIDTH(CNTW)
    ) dut (
        .CLK(CLK), .RST(RST), .ENABLE(ENABLE), .START(START),
        .ADC_DATA(ADC_DATA), .ADC_VALID(ADC_VALID), .DAC_SEL(DAC_SEL), .BUSY(BUSY),
        .J_PLUS(J_PLUS), .J_MINUS(J_MINUS), .DJ(DJ), .DJ_VALID(DJ_VALID)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int failures = 0;
    int exp_jp = 0, exp_jm = 0, exp_dj = 0;
    int nxt_jp, nxt_jm;
    bit vld_a [MAXE];
    int dat_a [MAXE];
    int lp, lm;

    function automatic int rnd_sample();
        return int'($urandom_range(16383, 0)) - 8192;
    endfunction

    // vmode: 0 always valid, 1 every third edge, 2 random density
    task automatic build(input int vmode, input int pv, input int mv, input int fill);
        int cnt;
        int e;
        int dens;
        dens = int'($urandom_range(4, 1));
        for (int i = 0; i < MAXE; i++) begin
            case (vmode)
                0:       vld_a[i] = 1'b1;
                1:       vld_a[i] = (i % 3 == 0);
                default: vld_a[i] = ($urandom_range(dens - 1, 0) == 0);
            endcase
            if (i >= 400) vld_a[i] = 1'b1;
            dat_a[i] = (fill == RANDV) ? rnd_sample() : fill;
        end
        nxt_jp = 0; nxt_jm = 0; cnt = 0; e = SETTLE + 1;
        while (cnt < N && e < MAXE) begin
            if (vld_a[e]) begin
                dat_a[e] = (pv == RANDV) ? rnd_sample() : pv;
                nxt_jp += dat_a[e]; cnt++; lp = e;
            end
            e++;
        end
        cnt = 0; e = lp + SETTLE + 1;
        while (cnt < N && e < MAXE) begin
            if (vld_a[e]) begin
                dat_a[e] = (mv == RANDV) ? rnd_sample() : mv;
                nxt_jm += dat_a[e]; cnt++; lm = e;
            end
            e++;
        end
    endtask

    task automatic run_seq(input string name, input bit noise, input int abort_e);
        int last;
        logic [1:0] edac;
        logic ebusy, edjv;
        last = (abort_e >= 0) ? abort_e : lm + 2;
        for (int e = 0; e <= last; e++) begin
            if (e == 0)               START = 1'b1;
            else if (e == lm + 1)     START = noise;
            else if (noise && e <= lm) START = $urandom_range(1, 0) == 1;
            else                      START = 1'b0;
            ENABLE    = (e != abort_e);
            ADC_VALID = vld_a[e];
            ADC_DATA  = ADC_W'(dat_a[e]);
            @(posedge CLK); #1;
            if (abort_e >= 0 && e >= abort_e) begin
                edac = 2'b00; ebusy = 1'b0; edjv = 1'b0;
            end else begin
                edac  = (e < lp) ? 2'b01 : (e < lm) ? 2'b10 : 2'b11;
                ebusy = (e <= lm);
                edjv  = (e == lm);
            end
            checks++;
            if (DAC_SEL !== edac) begin
                failures++;
                $display("FAIL %s dac_sel edge %0d: got %b want %b", name, e, DAC_SEL, edac);
            end
            checks++;
            if (BUSY !== ebusy) begin
                failures++;
                $display("FAIL %s busy edge %0d: got %b want %b", name, e, BUSY, ebusy);
            end
            checks++;
            if (DJ_VALID !== edjv) begin
                failures++;
                $display("FAIL %s dj_valid edge %0d: got %b want %b", name, e, DJ_VALID, edjv);
            end
            if ((e == lm && abort_e < 0) || e == abort_e || e == last) begin
                if (e == lm && abort_e < 0) begin
                    exp_jp = nxt_jp; exp_jm = nxt_jm; exp_dj = nxt_jp - nxt_jm;
                end
                checks++;
                if (J_PLUS !== SW'(exp_jp) || J_MINUS !== SW'(exp_jm) || DJ !== (SW+1)'(exp_dj)) begin
                    failures++;
                    $display("FAIL %s results edge %0d: got jp=%0d jm=%0d dj=%0d want jp=%0d jm=%0d dj=%0d",
                             name, e, $signed(J_PLUS), $signed(J_MINUS), $signed(DJ), exp_jp, exp_jm, exp_dj);
                end
            end
        end
        START = 1'b0; ENABLE = 1'b1; ADC_VALID = 1'b0;
        if (abort_e >= 0) begin
            @(posedge CLK); #1;
            checks++;
            if (DAC_SEL !== 2'b11 || BUSY !== 1'b0) begin
                failures++;
                $display("FAIL %s reenable: got dac=%b busy=%b want dac=11 busy=0", name, DAC_SEL, BUSY);
            end
        end
    endtask

    task automatic test_reset();
        RST = 1'b1; ENABLE = 1'b0; START = 1'b0; ADC_VALID = 1'b0; ADC_DATA = '0;
        repeat (2) @(posedge CLK);
        #1;
        checks++;
        if (DAC_SEL !== 2'b00 || BUSY !== 1'b0 || DJ_VALID !== 1'b0 ||
            J_PLUS !== '0 || J_MINUS !== '0 || DJ !== '0) begin
            failures++;
            $display("FAIL reset_values: got dac=%b busy=%b djv=%b jp=%0d jm=%0d dj=%0d want all zero",
                     DAC_SEL, BUSY, DJ_VALID, J_PLUS, J_MINUS, DJ);
        end
        RST = 1'b0;
        @(posedge CLK); #1;
        checks++;
        if (DAC_SEL !== 2'b00) begin
            failures++;
            $display("FAIL reset_disabled_dac: got %b want 00", DAC_SEL);
        end
        ENABLE = 1'b1;
        @(posedge CLK); #1;
        checks++;
        if (DAC_SEL !== 2'b11 || BUSY !== 1'b0) begin
            failures++;
            $display("FAIL reset_enabled_idle: got dac=%b busy=%b want dac=11 busy=0", DAC_SEL, BUSY);
        end
    endtask

    task automatic test_nominal();
        build(0, 100, -50, 0);
        run_seq("nominal", 1'b0, -1);
    endtask

    task automatic test_extremes();
        build(0, 8191, -8192, RANDV);
        run_seq("extremes", 1'b0, -1);
    endtask

    task automatic test_sparse_valid();
        build(1, 10, 10, 999);
        run_seq("sparse_valid", 1'b0, -1);
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 3; k++) begin
            build(2, RANDV, RANDV, RANDV);
            run_seq("back_to_back", 1'b1, -1);
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 4; k++) begin
            build(int'($urandom_range(2, 0)), RANDV, RANDV, RANDV);
            run_seq("random", 1'b0, -1);
        end
    endtask

    task automatic test_enable_abort();
        build(0, RANDV, RANDV, RANDV);
        run_seq("enable_abort", 1'b0, lp + SETTLE + 3);
        build(2, RANDV, RANDV, RANDV);
        run_seq("after_abort", 1'b0, -1);
    endtask

    task automatic test_async_reset();
        build(0, RANDV, RANDV, RANDV);
        for (int e = 0; e <= lp + SETTLE / 2; e++) begin
            START = (e == 0); ENABLE = 1'b1;
            ADC_VALID = vld_a[e]; ADC_DATA = ADC_W'(dat_a[e]);
            @(posedge CLK); #1;
        end
        START = 1'b0;
        checks++;
        if (DAC_SEL !== 2'b10) begin
            failures++;
            $display("FAIL async_reset_pre: got dac=%b want 10", DAC_SEL);
        end
        #2 RST = 1'b1;
        #1;
        exp_jp = 0; exp_jm = 0; exp_dj = 0;
        checks++;
        if (DAC_SEL !== 2'b00 || BUSY !== 1'b0 || DJ_VALID !== 1'b0 ||
            J_PLUS !== '0 || J_MINUS !== '0 || DJ !== '0) begin
            failures++;
            $display("FAIL async_reset_immediate: got dac=%b busy=%b jp=%0d jm=%0d dj=%0d want zeros",
                     DAC_SEL, BUSY, J_PLUS, J_MINUS, DJ);
        end
        @(negedge CLK);
        RST = 1'b0;
        @(posedge CLK); #1;
        checks++;
        if (DAC_SEL !== 2'b11 || BUSY !== 1'b0 || J_PLUS !== '0) begin
            failures++;
            $display("FAIL async_reset_release: got dac=%b busy=%b jp=%0d want dac=11 busy=0 jp=0",
                     DAC_SEL, BUSY, J_PLUS);
        end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_extremes();
        test_sparse_valid();
        test_back_to_back();
        test_random();
        test_enable_abort();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
